// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB4 bus bundle for apb_cmd_master.
// The master modport is the initiator side; slave is the command source / peripheral side.
interface apb_cmd_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [STRB_WIDTH-1:0] cmd_strb_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic [ADDR_WIDTH-1:0] paddr_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB4 initiator: turns a valid/ready command stream into single APB transfers
// and returns a valid/ready response with read data, slave error and timeout status.
module apb_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    apb_cmd_master_if.master    bus,
    output logic                busy_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 accept_c;
    logic                 done_c;
    logic                 tmo_hit_c;

    // Counter holds the number of wait states already seen, so the hit fires on the last allowed one.
    assign tmo_hit_c = TMO_EN && (wait_cnt == CNT_LAST);

    // Next-state logic; pready in the final allowed cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                    accept_c  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready_i || tmo_hit_c) begin
                    done_c    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait-state counter: cleared while in SETUP, saturating count of ACCESS cycles without pready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !bus.pready_i && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
    end

    // Control outputs are registered from the next state so they align with the state itself;
    // cmd_ready staying low in reset doubles as the out-of-reset flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd_ready_o   <= 1'b0;
            bus.psel_o        <= 1'b0;
            bus.penable_o     <= 1'b0;
            bus.rsp_valid_o   <= 1'b0;
            busy_o            <= 1'b0;
            bus.paddr_o       <= '0;
            bus.pwrite_o      <= 1'b0;
            bus.pwdata_o      <= '0;
            bus.pstrb_o       <= '0;
            bus.rsp_rdata_o   <= '0;
            bus.rsp_err_o     <= 1'b0;
            bus.rsp_timeout_o <= 1'b0;
        end else begin
            bus.cmd_ready_o <= (state_nxt == ST_IDLE);
            bus.psel_o      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
            bus.penable_o   <= (state_nxt == ST_ACCESS);
            bus.rsp_valid_o <= (state_nxt == ST_RESP);
            busy_o          <= (state_nxt != ST_IDLE);

            if (accept_c) begin
                bus.paddr_o  <= bus.cmd_addr_i;
                bus.pwrite_o <= bus.cmd_write_i;
                bus.pwdata_o <= bus.cmd_wdata_i;
                bus.pstrb_o  <= bus.cmd_write_i ? bus.cmd_strb_i : STRB_WIDTH'(0);
            end

            if (done_c) begin
                bus.rsp_rdata_o   <= (bus.pready_i && !bus.pwrite_o) ? bus.prdata_i : DATA_WIDTH'(0);
                bus.rsp_err_o     <= bus.pready_i ? bus.pslverr_i : 1'b1;
                bus.rsp_timeout_o <= !bus.pready_i;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: a cycle-timeline model derived from the
// transfer timing rules is compared against the DUT on every falling edge.
module tb_apb_cmd_master;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 16;
    localparam int NONE = -100000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: t_acc is the cycle count right after the accepting edge.
    int          t_acc     = NONE;
    int          n_acc     = 0;
    int          hold      = 0;
    int          ready_idx = 0;
    bit          in_reset  = 1'b1;
    int          rel_cyc   = 1 << 30;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic          m_slverr;
    logic [DW-1:0] m_srdata;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    logic          e_tmo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Peripheral and response-consumer behaviour, driven from the model timeline.
    always @(posedge clk) begin : slave_drv
        int d;
        #3;
        d = cyc - t_acc;
        bus.pready_i    = (ready_idx != 0) && (d >= 1) && (d == ready_idx);
        bus.pslverr_i   = bus.pready_i ? m_slverr : 1'b1;
        bus.prdata_i    = bus.pready_i ? m_srdata : (DW'(d) ^ 32'hBAD0_0000);
        bus.rsp_ready_i = !((d > n_acc) && (d <= n_acc + hold));
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        int d;
        logic in_setup, in_acc, in_resp, idle;
        d        = cyc - t_acc;
        in_setup = !in_reset && (d == 0);
        in_acc   = !in_reset && (d >= 1) && (d <= n_acc);
        in_resp  = !in_reset && (d > n_acc) && (d <= n_acc + 1 + hold);
        idle     = !(in_setup || in_acc || in_resp);
        chk("psel",      64'(bus.psel_o),      64'(in_setup || in_acc));
        chk("penable",   64'(bus.penable_o),   64'(in_acc));
        chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(in_resp));
        chk("busy",      64'(busy),            64'(!idle));
        chk("cmd_ready", 64'(bus.cmd_ready_o), 64'(idle && !in_reset && (cyc > rel_cyc)));
        if (in_setup || in_acc) begin
            chk("paddr",  64'(bus.paddr_o),  64'(m_addr));
            chk("pwrite", 64'(bus.pwrite_o), 64'(m_write));
            chk("pwdata", 64'(bus.pwdata_o), 64'(m_wdata));
            chk("pstrb",  64'(bus.pstrb_o),  64'(m_write ? m_strb : SW'(0)));
        end
        if (in_resp) begin
            chk("rsp_rdata",   64'(bus.rsp_rdata_o),   64'(e_rdata));
            chk("rsp_err",     64'(bus.rsp_err_o),     64'(e_err));
            chk("rsp_timeout", 64'(bus.rsp_timeout_o), 64'(e_tmo));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_model(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [SW-1:0] s, input int rdy, input logic serr,
                             input logic [DW-1:0] srd, input int hld);
        m_write = w; m_addr = a; m_wdata = wd; m_strb = s;
        m_slverr = serr; m_srdata = srd; ready_idx = rdy; hold = hld;
        if ((rdy != 0) && (rdy <= int'(TMO))) begin
            n_acc = rdy; e_rdata = w ? '0 : srd; e_err = serr; e_tmo = 1'b0;
        end else begin
            n_acc = int'(TMO); e_rdata = '0; e_err = 1'b1; e_tmo = 1'b1;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = w;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = wd;
        bus.cmd_strb_i  = s;
        t_acc = cyc + 1;
    endtask

    // One transfer from accept to the following idle cycle, with literal pins on the result.
    task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [SW-1:0] s, input int rdy, input logic serr,
                           input logic [DW-1:0] srd, input int hld, input bit keep,
                           input int lit_psel, input int lit_pen, input logic [DW-1:0] lit_rdata,
                           input logic lit_err, input logic lit_tmo);
        int npsel = 0;
        int npen  = 0;
        set_model(w, a, wd, s, rdy, serr, srd, hld);
        for (int i = 0; i <= n_acc + 1 + hld; i++) begin
            step();
            if (i == 0 && !keep) begin
                bus.cmd_valid_i = 1'b0;
                bus.cmd_write_i = ~w;
                bus.cmd_addr_i  = ~a;
                bus.cmd_wdata_i = ~wd;
                bus.cmd_strb_i  = ~s;
            end
            npsel += int'(bus.psel_o);
            npen  += int'(bus.penable_o);
            if (i == n_acc + 1) begin
                chk("lit_rsp_valid", 64'(bus.rsp_valid_o),   64'(1));
                chk("lit_rdata",     64'(bus.rsp_rdata_o),   64'(lit_rdata));
                chk("lit_err",       64'(bus.rsp_err_o),     64'(lit_err));
                chk("lit_timeout",   64'(bus.rsp_timeout_o), 64'(lit_tmo));
            end
        end
        step();
        chk("lit_psel_cycles",    64'(npsel), 64'(lit_psel));
        chk("lit_penable_cycles", 64'(npen),  64'(lit_pen));
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_strb_i  = '0;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_cmd_ready", 64'(bus.cmd_ready_o), 64'(0));
        rst_n    = 1'b1;
        in_reset = 1'b0;
        rel_cyc  = cyc;
        step();
        chk("ready_after_reset", 64'(bus.cmd_ready_o), 64'(1));

        // w, addr, wdata, strb, ready_idx, slverr, slave rdata, hold, keep, psel, pen, rdata, err, tmo
        run_txn(1'b1, 8'h00, 32'h0000_0041, 4'h1,  1, 1'b0, 32'h1234_5678,  0, 1'b0,  2,  1, 32'h0,          1'b0, 1'b0);
        run_txn(1'b0, 8'h14, 32'h0,         4'hF,  4, 1'b0, 32'hDEAD_BEEF,  0, 1'b0,  5,  4, 32'hDEAD_BEEF,  1'b0, 1'b0);
        run_txn(1'b1, 8'h18, 32'hA5A5_0001, 4'h3,  1, 1'b1, 32'h0,          0, 1'b0,  2,  1, 32'h0,          1'b1, 1'b0);
        run_txn(1'b0, 8'h20, 32'h0,         4'hF,  2, 1'b0, 32'h0BAD_F00D,  0, 1'b0,  3,  2, 32'h0BAD_F00D,  1'b0, 1'b0);
        run_txn(1'b0, 8'h24, 32'h0,         4'h0,  0, 1'b0, 32'h1111_1111,  0, 1'b0, 17, 16, 32'h0,          1'b1, 1'b1);
        run_txn(1'b0, 8'h28, 32'h0,         4'h0, 16, 1'b0, 32'hCAFE_0016,  0, 1'b0, 17, 16, 32'hCAFE_0016,  1'b0, 1'b0);
        run_txn(1'b1, 8'h2C, 32'h7777_0000, 4'hC, 17, 1'b0, 32'h2222_2222,  0, 1'b0, 17, 16, 32'h0,          1'b1, 1'b1);
        run_txn(1'b1, 8'h30, 32'h0000_00C3, 4'h8,  1, 1'b0, 32'h0,         10, 1'b1,  2,  1, 32'h0,          1'b0, 1'b0);
        run_txn(1'b0, 8'h34, 32'h0,         4'h0,  1, 1'b0, 32'h55AA_55AA,  0, 1'b0,  2,  1, 32'h55AA_55AA,  1'b0, 1'b0);

        // Reset pulsed during ACCESS of a read whose slave never answers.
        set_model(1'b0, 8'h40, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0);
        step();
        bus.cmd_valid_i = 1'b0;
        step();
        step();
        chk("pre_reset_penable", 64'(bus.penable_o), 64'(1));
        rst_n    = 1'b0;
        in_reset = 1'b1;
        t_acc    = NONE;
        #1;
        chk("mid_reset_psel",      64'(bus.psel_o),      64'(0));
        chk("mid_reset_penable",   64'(bus.penable_o),   64'(0));
        chk("mid_reset_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("mid_reset_cmd_ready", 64'(bus.cmd_ready_o), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        rel_cyc  = cyc;
        step();
        chk("post_reset_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
        chk("post_reset_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));

        run_txn(1'b0, 8'h44, 32'h0, 4'h0, 3, 1'b0, 32'h0000_ABCD, 0, 1'b0, 4, 3, 32'h0000_ABCD, 1'b0, 1'b0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
